// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register indices, FSM states and
// the byte-lane mask helper used by the bus write path.
package intc_pkg;

  localparam logic [2:0] REG_ENABLE   = 3'd0;
  localparam logic [2:0] REG_PENDING  = 3'd1;
  localparam logic [2:0] REG_CLAIM    = 3'd2;
  localparam logic [2:0] REG_COMPLETE = 3'd3;
  localparam logic [2:0] REG_OVERFLOW = 3'd4;

  localparam int unsigned SRC_IDX_W  = 5;
  localparam logic [7:0]  CLAIM_NONE = 8'd0;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StAsserted  = 2'd1,
    StInService = 2'd2
  } intc_state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] lanes);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{lanes[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Fixed-priority encoder: reports the lowest-indexed active request and whether any
// request is active at all.
module intc_priority_encoder
  import intc_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 8
) (
  input  logic [NUM_SOURCES-1:0] req_i,
  output logic [SRC_IDX_W-1:0]   idx_o,
  output logic                   found_o
);

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = i[SRC_IDX_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Bus-attached interrupt controller: latches source pulses, masks, prioritises and runs a
// claim/complete handshake. Define INTC_OVERFLOW_CNT_EN to build the overflow counter (reg 4).
module interrupt_controller
  import intc_pkg::*;
#(
  parameter logic [31:0] START_ADDR  = 32'h0,
  parameter int unsigned NUM_SOURCES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] intr_src,
  output logic                   cpu_intr,
  input  logic [31:0]            addr_bus,
  inout  wire  [31:0]            data_bus,
  input  logic                   rd_bus,
  input  logic                   wr_bus,
  input  logic [3:0]             data_mask_bus,
  output logic                   fc_bus
);

  logic [NUM_SOURCES-1:0] enable_q, enable_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [7:0]             claim_id_q, claim_id_d;
  intc_state_e            state_q, state_d;
  logic                   cpu_intr_q, cpu_intr_d;
  logic                   data_written_q, data_written_d;
  logic                   claim_done_q, claim_done_d;

  logic [31:0]            offset;
  logic                   hit;
  logic [2:0]             reg_idx;
  logic                   rd_hit;
  logic                   wr_fire;
  logic [31:0]            wmask;
  logic [31:0]            wdata;
  logic [31:0]            rdata;

  logic [NUM_SOURCES-1:0] req;
  logic [SRC_IDX_W-1:0]   src_idx;
  logic                   found;
  logic [7:0]             enc_id;
  logic                   claim_rd;
  logic                   claim_fire;
  logic                   complete_hit;
  logic [NUM_SOURCES-1:0] claim_mask;

  // Offset-based decode keeps the window correct for any START_ADDR.
  assign offset  = addr_bus - START_ADDR;
  assign hit     = (offset[31:5] == 27'd0);
  assign reg_idx = offset[4:2];
  assign rd_hit  = hit && rd_bus;
  assign wr_fire = hit && wr_bus && !data_written_q;
  assign wmask   = byte_mask(data_mask_bus);
  assign wdata   = data_bus & wmask;

  assign req = pending_q & enable_q;

  intc_priority_encoder #(
    .NUM_SOURCES(NUM_SOURCES)
  ) u_prio (
    .req_i  (req),
    .idx_o  (src_idx),
    .found_o(found)
  );

  assign enc_id       = {3'b000, src_idx} + 8'd1;
  assign claim_rd     = rd_hit && (reg_idx == REG_CLAIM) && !claim_done_q;
  assign claim_fire   = claim_rd && (state_q == StAsserted) && found;
  assign complete_hit = wr_fire && (reg_idx == REG_COMPLETE) && data_mask_bus[0] &&
                        (data_bus[7:0] == claim_id_q);

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      claim_mask[i] = claim_fire && (src_idx == i[SRC_IDX_W-1:0]);
    end
  end

  // New pulses are OR-ed in last so a set always beats a clear on the same edge.
  always_comb begin
    enable_d  = enable_q;
    pending_d = pending_q;
    if (wr_fire && (reg_idx == REG_ENABLE)) begin
      enable_d = (enable_q & ~wmask[NUM_SOURCES-1:0]) | wdata[NUM_SOURCES-1:0];
    end
    if (wr_fire && (reg_idx == REG_PENDING)) begin
      pending_d = pending_d & ~wdata[NUM_SOURCES-1:0];
    end
    pending_d = (pending_d & ~claim_mask) | intr_src;
  end

  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    unique case (state_q)
      StIdle: begin
        if (found) state_d = StAsserted;
      end
      StAsserted: begin
        if (!found) begin
          state_d = StIdle;
        end else if (claim_fire) begin
          state_d    = StInService;
          claim_id_d = enc_id;
        end
      end
      StInService: begin
        if (complete_hit) begin
          state_d    = StIdle;
          claim_id_d = CLAIM_NONE;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_intr_d     = (state_d == StAsserted);
  assign data_written_d = wr_bus && (data_written_q || wr_fire);
  assign claim_done_d   = rd_bus && (claim_done_q || claim_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q       <= '0;
      pending_q      <= '0;
      claim_id_q     <= CLAIM_NONE;
      state_q        <= StIdle;
      cpu_intr_q     <= 1'b0;
      data_written_q <= 1'b0;
      claim_done_q   <= 1'b0;
    end else begin
      enable_q       <= enable_d;
      pending_q      <= pending_d;
      claim_id_q     <= claim_id_d;
      state_q        <= state_d;
      cpu_intr_q     <= cpu_intr_d;
      data_written_q <= data_written_d;
      claim_done_q   <= claim_done_d;
    end
  end

`ifdef INTC_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // At most one increment per cycle however many sources overflow together.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_fire && (reg_idx == REG_OVERFLOW)) begin
      ovf_cnt_d = '0;
    end else if (|(intr_src & pending_q) && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end
`endif

  // Before the claiming edge the encoder result is bypassed so the id is stable all strobe.
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_ENABLE:  rdata[NUM_SOURCES-1:0] = enable_q;
      REG_PENDING: rdata[NUM_SOURCES-1:0] = pending_q;
      REG_CLAIM: begin
        if (claim_done_q) begin
          rdata[7:0] = claim_id_q;
        end else if ((state_q == StAsserted) && found) begin
          rdata[7:0] = enc_id;
        end
      end
`ifdef INTC_OVERFLOW_CNT_EN
      REG_OVERFLOW: rdata[15:0] = ovf_cnt_q;
`endif
      default: rdata = '0;
    endcase
  end

  assign data_bus = rd_hit ? rdata : 'z;
  assign fc_bus   = hit ? (rd_hit | data_written_q) : 1'bz;
  assign cpu_intr = cpu_intr_q;

  logic unused_bus;
  assign unused_bus = ^{offset[1:0], data_bus, wmask, wdata};

endmodule
